// File: rtl/absorb_sequencer.sv
// absorb_sequencer
//   Control stage ahead of the SHAKE padding generator. Forwards message words
//   with their per-word padding controls, appends padding-only words to close
//   the final rate block, and flags block boundaries for the permutation stage.
//
// Ports:
//   clk, rst                 clock, synchronous active-high reset
//   start, mode, msg_len     begin message (IDLE only); mode 0=SHAKE128, 1=SHAKE256
//   din, din_valid/ready     message words, valid bytes packed from bits 63:56 down
//   dout, dout_valid/ready   word to padder data_in
//   perm_busy                permutation running; stalls all transfers
//   remaining_valid_bytes    valid bytes in current word (0..8)
//   padding_enable           padding applies to current word
//   last_word_in_block       current word closes the rate block
//   padding_reset            clears the padder first-pad latch (high in IDLE)
//   block_end, msg_done      one-cycle pulses qualified by the dout transfer
//   busy                     sequencer not idle
//   block_count (opt)        blocks completed in current message, saturating;
//                            present only when ABSORB_BLOCK_COUNT_EN is defined
module absorb_sequencer #(
    parameter int unsigned LEN_WIDTH     = 32,
    parameter int unsigned RATE128_WORDS = 21,
    parameter int unsigned RATE256_WORDS = 17,
    parameter int unsigned W             = 64,
    localparam int unsigned BW           = $clog2(W / 8)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic                 mode,
    input  logic [LEN_WIDTH-1:0] msg_len,
    input  logic [W-1:0]         din,
    input  logic                 din_valid,
    output logic                 din_ready,
    output logic [W-1:0]         dout,
    output logic                 dout_valid,
    input  logic                 dout_ready,
    input  logic                 perm_busy,
    output logic [BW:0]          remaining_valid_bytes,
    output logic                 padding_enable,
    output logic                 last_word_in_block,
    output logic                 padding_reset,
    output logic                 block_end,
    output logic                 msg_done,
    output logic                 busy
`ifdef ABSORB_BLOCK_COUNT_EN
    ,
    output logic [15:0]          block_count
`endif
);

    typedef enum logic [1:0] {IDLE, MSG, PAD} state_t;

    state_t               state, state_nxt;
    logic [LEN_WIDTH-1:0] bytes_left;
    logic [4:0]           word_idx;
    logic                 mode_q;

    logic [4:0]           rate_m1;
    logic                 is_last;
    logic                 short_word;
    logic                 xfer;

    assign rate_m1    = mode_q ? 5'(RATE256_WORDS - 1) : 5'(RATE128_WORDS - 1);
    assign is_last    = (word_idx == rate_m1);
    assign short_word = (bytes_left < LEN_WIDTH'(W / 8));
    assign xfer       = dout_valid && dout_ready;

    always_comb begin
        state_nxt             = state;
        dout                  = '0;
        dout_valid            = 1'b0;
        din_ready             = 1'b0;
        remaining_valid_bytes = '0;
        padding_enable        = 1'b0;
        last_word_in_block    = 1'b0;
        padding_reset         = 1'b1;
        block_end             = 1'b0;
        msg_done              = 1'b0;
        busy                  = 1'b0;
        case (state)
            IDLE: begin
                if (start)
                    state_nxt = (msg_len != '0) ? MSG : PAD;
            end
            MSG: begin
                busy                  = 1'b1;
                padding_reset         = 1'b0;
                dout                  = din;
                dout_valid            = din_valid && !perm_busy;
                din_ready             = dout_ready && !perm_busy;
                remaining_valid_bytes = short_word ? bytes_left[BW:0] : (BW+1)'(W / 8);
                padding_enable        = short_word;
                last_word_in_block    = is_last;
                if (xfer) begin
                    block_end = is_last;
                    if (short_word) begin
                        // Short word closing a block carries the whole padding.
                        msg_done  = is_last;
                        state_nxt = is_last ? IDLE : PAD;
                    end else if (bytes_left == LEN_WIDTH'(W / 8)) begin
                        // Exact word boundary: padding still needs its own word(s).
                        state_nxt = PAD;
                    end
                end
            end
            PAD: begin
                busy               = 1'b1;
                padding_reset      = 1'b0;
                dout_valid         = !perm_busy;
                padding_enable     = 1'b1;
                last_word_in_block = is_last;
                if (xfer) begin
                    block_end = is_last;
                    msg_done  = is_last;
                    if (is_last)
                        state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            bytes_left <= '0;
            word_idx   <= '0;
            mode_q     <= 1'b0;
        end else begin
            state <= state_nxt;
            if (state == IDLE && start) begin
                bytes_left <= msg_len;
                mode_q     <= mode;
                word_idx   <= '0;
            end
            if (xfer) begin
                word_idx <= is_last ? 5'd0 : word_idx + 5'd1;
                if (state == MSG)
                    bytes_left <= bytes_left - LEN_WIDTH'(remaining_valid_bytes);
            end
        end
    end

`ifdef ABSORB_BLOCK_COUNT_EN
    always_ff @(posedge clk) begin
        if (rst)
            block_count <= '0;
        else if (state == IDLE && start)
            block_count <= '0;
        else if (block_end && block_count != '1)
            block_count <= block_count + 16'd1;
    end
`endif

endmodule

// File: tb/tb_absorb_sequencer.sv
module tb_absorb_sequencer;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic        mode;
    logic [31:0] msg_len;
    logic [63:0] din;
    logic        din_valid;
    logic        din_ready;
    logic [63:0] dout;
    logic        dout_valid;
    logic        dout_ready;
    logic        perm_busy;
    logic [3:0]  remaining_valid_bytes;
    logic        padding_enable;
    logic        last_word_in_block;
    logic        padding_reset;
    logic        block_end;
    logic        msg_done;
    logic        busy;

    always #5 clk = ~clk;

    absorb_sequencer #(
        .LEN_WIDTH(32),
        .RATE128_WORDS(21),
        .RATE256_WORDS(17)
    ) dut (
        .clk(clk),
        .rst(rst),
        .start(start),
        .mode(mode),
        .msg_len(msg_len),
        .din(din),
        .din_valid(din_valid),
        .din_ready(din_ready),
        .dout(dout),
        .dout_valid(dout_valid),
        .dout_ready(dout_ready),
        .perm_busy(perm_busy),
        .remaining_valid_bytes(remaining_valid_bytes),
        .padding_enable(padding_enable),
        .last_word_in_block(last_word_in_block),
        .padding_reset(padding_reset),
        .block_end(block_end),
        .msg_done(msg_done),
        .busy(busy)
    );

    // {dout, remaining, padding_enable, last_word_in_block, block_end, msg_done, din_ready}
    typedef struct packed {
        logic [63:0] d;
        logic [3:0]  r;
        logic        pe;
        logic        lw;
        logic        be;
        logic        md;
        logic        dr;
    } item_t;

    item_t sb[$];
    int    checks   = 0;
    int    failures = 0;
    int    n_xfer   = 0;
    int    din_taken = 0;
    int    be_cnt   = 0;
    int    md_cnt   = 0;

    function automatic logic [63:0] pat(int unsigned k);
        logic [7:0] b;
        b = 8'(k * 7 + 17);
        return {8{b}} ^ 64'hF0E1_D2C3_B4A5_9687;
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Monitor: samples on the falling edge, away from the active edge.
    always @(negedge clk) begin
        if (!rst) begin
            if (perm_busy) begin
                chk("valid_under_perm_busy", 64'(dout_valid), 64'd0);
                chk("din_ready_under_perm_busy", 64'(din_ready), 64'd0);
            end
            if (!dout_ready && busy)
                chk("din_ready_under_backpressure", 64'(din_ready), 64'd0);
            if (dout_valid && dout_ready) begin
                item_t act, exp;
                act = {dout, remaining_valid_bytes, padding_enable, last_word_in_block,
                       block_end, msg_done, din_ready};
                checks++;
                if (sb.size() == 0) begin
                    failures++;
                    $display("FAIL unexpected_word: got %h expected none", act);
                end else begin
                    exp = sb.pop_front();
                    if (act !== exp) begin
                        failures++;
                        $display("FAIL word%0d: got %h expected %h", n_xfer, act, exp);
                    end
                end
                n_xfer++;
                if (din_valid && din_ready) din_taken++;
                if (block_end) be_cnt++;
                if (msg_done) md_cnt++;
            end
        end
    end

    // Expected word stream; totals and rate per message are supplied by hand.
    task automatic expect_msg(input int unsigned len, input int unsigned rate, input int unsigned total);
        int unsigned nm;
        nm = (len + 7) / 8;
        for (int unsigned k = 0; k < total; k++) begin
            item_t it;
            if (k < nm) begin
                it.d  = pat(k);
                it.r  = (len - 8 * k >= 8) ? 4'd8 : 4'(len - 8 * k);
                it.pe = (len - 8 * k < 8);
                it.dr = 1'b1;
            end else begin
                it.d  = '0;
                it.r  = '0;
                it.pe = 1'b1;
                it.dr = 1'b0;
            end
            it.lw = (k % rate == rate - 1);
            it.be = it.lw;
            it.md = (k == total - 1);
            sb.push_back(it);
        end
    endtask

    task automatic run_msg(input int unsigned len, input logic md, input int unsigned total,
                           input bit stall_en);
        int din_base, md_base, be_seen, xfer_base, busy_cnt, rdy_held, cyc;
        expect_msg(len, md ? 17 : 21, total);
        din_base  = din_taken;
        md_base   = md_cnt;
        xfer_base = n_xfer;
        be_seen   = be_cnt;
        busy_cnt  = 0;
        rdy_held  = 0;
        start   = 1'b1;
        msg_len = 32'(len);
        mode    = md;
        din     = pat(0);
        @(posedge clk); #1;
        start = 1'b0;
        cyc   = 0;
        while (md_cnt == md_base && cyc < 400) begin
            din       = pat(din_taken - din_base);
            din_valid = 1'b1;
            if (stall_en && be_cnt != be_seen) begin
                be_seen  = be_cnt;
                busy_cnt = 3;
            end
            perm_busy = (busy_cnt > 0);
            if (busy_cnt > 0) busy_cnt--;
            if (stall_en && (n_xfer - xfer_base) == 5 && rdy_held < 2) begin
                dout_ready = 1'b0;
                rdy_held++;
            end else begin
                dout_ready = 1'b1;
            end
            @(posedge clk); #1;
            cyc++;
        end
        perm_busy  = 1'b0;
        dout_ready = 1'b1;
        chk("msg_done_seen", 64'(md_cnt - md_base), 64'd1);
        chk("word_count", 64'(n_xfer - xfer_base), 64'(total));
        chk("scoreboard_drained", 64'(sb.size()), 64'd0);
        sb.delete();
        @(negedge clk);
        chk("idle_after_msg", 64'(busy), 64'd0);
        @(posedge clk); #1;
    endtask

    initial begin
        int xb, cyc;
        rst = 1'b1; start = 1'b0; mode = 1'b0; msg_len = '0;
        din = '0; din_valid = 1'b1; dout_ready = 1'b1; perm_busy = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_dout_valid", 64'(dout_valid), 64'd0);
        chk("rst_din_ready", 64'(din_ready), 64'd0);
        chk("rst_padding_reset", 64'(padding_reset), 64'd1);
        chk("rst_padding_enable", 64'(padding_enable), 64'd0);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_dout", dout, 64'd0);
        chk("rst_pulses", 64'({block_end, msg_done}), 64'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        @(posedge clk); #1;

        run_msg(0,   1'b0, 21, 1'b0);
        run_msg(5,   1'b1, 17, 1'b0);
        run_msg(136, 1'b1, 34, 1'b0);
        run_msg(135, 1'b1, 17, 1'b0);
        run_msg(136, 1'b1, 34, 1'b1);

        // Reset while MSG word 4 is presented; the partial message is discarded.
        expect_msg(200, 21, 4);
        sb[3].md = 1'b0;
        xb = n_xfer;
        start = 1'b1; msg_len = 32'd200; mode = 1'b0; din = pat(0);
        @(posedge clk); #1;
        start = 1'b0;
        cyc = 0;
        while ((n_xfer - xb) < 4 && cyc < 50) begin
            din = pat(n_xfer - xb);
            @(posedge clk); #1;
            cyc++;
        end
        chk("pre_reset_words", 64'(n_xfer - xb), 64'd4);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        chk("midrst_busy", 64'(busy), 64'd0);
        chk("midrst_padding_reset", 64'(padding_reset), 64'd1);
        chk("midrst_dout_valid", 64'(dout_valid), 64'd0);
        chk("midrst_scoreboard", 64'(sb.size()), 64'd0);
        sb.delete();
        @(posedge clk); #1;
        run_msg(8, 1'b0, 21, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/absorb_sequencer.md
Name: absorb_sequencer

Overview:
- Control stage directly upstream of the SHAKE padding generator.
- Accepts a message byte length and a stream of w-bit message words. Forwards each word together with the per-word padding controls: remaining_valid_bytes, padding_enable, last_word_in_block and padding_reset.
- Synthesises any padding-only words needed to close the final rate block.
- Marks block boundaries so the absorb/permutation stage knows when to run Keccak-f.

Parameters:
- LEN_WIDTH, 32, width of message byte-length input.
- RATE128_WORDS, 21, words per rate block for SHAKE128 (168 B / 8).
- RATE256_WORDS, 17, words per rate block for SHAKE256 (136 B / 8).

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- start  in  1  begin message; sampled only in IDLE
- mode  in  1  0 = SHAKE128, 1 = SHAKE256; latched on start
- msg_len  in  LEN_WIDTH  message length in bytes; latched on start
- din  in  w  message word; valid bytes packed from lane 7 (bits 63:56) downward
- din_valid  in  1  din valid
- din_ready  out  1  din accepted when din_valid && din_ready
- dout  out  w  word to padder data_in
- dout_valid  out  1  dout valid
- dout_ready  in  1  downstream accepts dout
- perm_busy  in  1  permutation running; stalls all transfers
- remaining_valid_bytes  out  w_byte_width+1  valid bytes in current word (0..8)
- padding_enable  out  1  padding applies to current word
- last_word_in_block  out  1  current word is last of rate block
- padding_reset  out  1  clears padder first-pad latch
- block_end  out  1  last word of a block transferred this cycle
- msg_done  out  1  final padded word transferred this cycle
- busy  out  1  state != IDLE

Behaviour:
- States: IDLE, MSG, PAD. Registers:
  - bytes_left (LEN_WIDTH)
  - word_idx (5 b)
  - mode_q
- rate = mode_q ? RATE256_WORDS : RATE128_WORDS.
- Reset:
  - state IDLE; bytes_left = 0, word_idx = 0, mode_q = 0.
  - Outputs: dout_valid = 0, din_ready = 0, block_end = 0, msg_done = 0, padding_enable = 0, padding_reset = 1, busy = 0, dout = 0.
- rst asserted mid-message: IDLE on next edge; in-flight message is discarded.
- IDLE:
  - padding_reset = 1; all handshakes low.
  - On start: latch msg_len and mode, set word_idx = 0.
  - Next state: MSG if msg_len != 0, else PAD.
- Transfer xfer = dout_valid && dout_ready. dout_valid is never high while perm_busy = 1.
- MSG:
  - dout = din (combinational, zero latency).
  - dout_valid = din_valid && !perm_busy; din_ready = dout_ready && !perm_busy.
  - remaining_valid_bytes = min(bytes_left, 8).
  - padding_enable = (bytes_left < 8). Exactly 8 bytes left gives a full word with no padding.
- PAD:
  - dout = 0; dout_valid = !perm_busy; din_ready = 0.
  - remaining_valid_bytes = 0; padding_enable = 1.
- All non-IDLE states: last_word_in_block = (word_idx == rate-1); padding_reset = 0.
- On xfer:
  - word_idx increments, wrapping to 0 after rate-1.
  - block_end = last_word_in_block.
  - In MSG, bytes_left -= min(bytes_left, 8).
- MSG exits:
  - Transferred word had bytes_left < 8 and last_word_in_block: msg_done = 1, go to IDLE.
  - Transferred word had bytes_left < 8, not last of block: go to PAD.
  - Transferred word had bytes_left == 8: go to PAD. If this word was also last of block, PAD emits a full extra block.
- PAD exit: transfer with last_word_in_block gives msg_done = 1, go to IDLE.
- start while busy: ignored. din_valid in IDLE/PAD: ignored (not consumed).
- block_end and msg_done are combinational, qualified by xfer; high for exactly one transfer cycle.

Optional Feature:
- Macro ABSORB_BLOCK_COUNT_EN.
- Defined: adds output block_count[15:0]. It is cleared on start acceptance, increments on each block_end, and saturates at 16'hFFFF. Reset value 0.
- Undefined: port and counter absent; behaviour otherwise identical.

Test Plan:
- msg_len=0, mode=0, dout_ready=1: 21 PAD words.
  - word0 remaining=0, padding_enable=1.
  - word20 last_word_in_block=1 with block_end=1 and msg_done=1.
  - din_ready stays 0 throughout.
- msg_len=5, mode=1:
  - Word0 in MSG with remaining=5, padding_enable=1.
  - Words 1..16 in PAD; block_end and msg_done on 17th transfer.
- msg_len=136, mode=1:
  - 17 MSG words with padding_enable=0, block_end on 17th.
  - Then 17 PAD words with remaining=0; msg_done on transfer 34.
- msg_len=135, mode=1: word16 has remaining=7, padding_enable=1, last_word_in_block=1; msg_done on that transfer; total 17 transfers.
- Stalls: perm_busy=1 for 3 cycles after block_end, and dout_ready=0 mid-block.
  - dout_valid=0 under perm_busy; din_ready=0 in both cases.
  - word_idx and bytes_left frozen; stream resumes with no lost or duplicated words.
- rst=1 for one cycle during MSG word 4:
  - Next cycle IDLE with busy=0 and padding_reset=1.
  - New start with msg_len=8 yields 1 MSG + 20 PAD words (mode=0).
